// File: rtl/regfile_bank.sv
// General-purpose register file: NUM_RD combinational read ports, one write port, sequenced clear.
// Reads 0-latency, writes land on the edge; writes dropped while clr_busy. Define REGFILE_BYPASS_EN for write-through.
module regfile_bank #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(DEPTH - 2);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_zero;
    logic                w_wr_ok;

    assign w_wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    // clr_req outranks a same-cycle write; r_busy is low whenever the FSM is idle
    assign w_wr_ok   = wr_en && !w_wr_zero && !clr_req && !r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_wr_ok) begin
                        r_mem[wr_addr] <= wr_data;
                    end
                end
                S_CLEAR: begin
                    r_mem[r_cnt] <= '0;
                    r_cnt        <= r_cnt + 1'b1;
                    // done is raised one edge early so it is high while cnt == DEPTH-1
                    r_done       <= (r_cnt == PRE_LAST);
                    if (r_cnt == LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign clr_busy = r_busy;
    assign clr_done = r_done;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_fwd;
        logic [DATA_W-1:0] w_dat;

        assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
`ifdef REGFILE_BYPASS_EN
        assign w_fwd  = rd_en[gi] && w_wr_ok && (w_addr == wr_addr);
`else
        assign w_fwd  = 1'b0;
`endif

        always_comb begin
            w_dat = '0;
            if (rd_en[gi] && !w_zero && !r_busy)
                w_dat = w_fwd ? wr_data : r_mem[w_addr];
        end

        assign rd_data[gi*DATA_W +: DATA_W] = w_dat;
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank (DATA_W=16, ADDR_W=5, NUM_RD=2, ZERO_REG=1).
module tb_regfile_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_en;
    logic [31:0] rd_data;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    regfile_bank #(.DATA_W(16), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    int          errs   = 0;
    int          checks = 0;
    logic [15:0] m [32];
    logic [15:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mexp(input logic [4:0] a, input logic e);
        return (e && a != 5'd0) ? m[a] : 16'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        if (a != 5'd0) m[a] = d;
    endtask

    task automatic rd2(input string tag, input logic [4:0] a0, input logic e0,
                       input logic [4:0] a1, input logic e1);
        rd_addr = {a1, a0};
        rd_en   = {e1, e0};
        exp_q.push_back(mexp(a0, e0));
        exp_q.push_back(mexp(a1, e1));
        #1;
        chk({tag, "_A"}, {16'h0, rd_data[15:0]},  {16'h0, exp_q.pop_front()});
        chk({tag, "_B"}, {16'h0, rd_data[31:16]}, {16'h0, exp_q.pop_front()});
    endtask

    task automatic zero_model();
        for (int i = 0; i < 32; i++) m[i] = 16'h0;
    endtask

    initial begin
        int n, done_cyc, done_cnt;
        logic [15:0] old;
        zero_model();
        rst_n = 1'b0; rd_addr = '0; rd_en = '0; wr_addr = '0; wr_en = 1'b0;
        wr_data = '0; clr_req = 1'b0;
        #1;
        rd2("reset_rd", 5'd0, 1'b1, 5'd7, 1'b1);
        chk("reset_busy", {31'h0, clr_busy}, 32'h0);
        chk("reset_done", {31'h0, clr_done}, 32'h0);
        #20 rst_n = 1'b1;
        tick();

        // zero register ignores writes
        wr(5'd0, 16'hFFFF);
        rd2("r0_write", 5'd0, 1'b1, 5'd0, 1'b1);

        wr(5'd3, 16'd313);
        rd2("r3", 5'd3, 1'b1, 5'd3, 1'b0);
        rd2("r3_en0", 5'd3, 1'b0, 5'd3, 1'b1);

        wr(5'd5, 16'd14);
        wr(5'd6, 16'd7);
        rd2("same_addr", 5'd5, 1'b1, 5'd5, 1'b1);
        rd2("diff_addr", 5'd5, 1'b1, 5'd6, 1'b1);

        // same-cycle write and read
        old = m[3];
        rd_addr = {5'd0, 5'd3}; rd_en = 2'b11;
        wr_addr = 5'd3; wr_data = 16'h1234; wr_en = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_fwd", {16'h0, rd_data[15:0]}, 32'h1234);
`else
        chk("same_cycle_old", {16'h0, rd_data[15:0]}, {16'h0, old});
`endif
        chk("same_cycle_r0", {16'h0, rd_data[31:16]}, 32'h0);
        tick();
        wr_en = 1'b0;
        m[3] = 16'h1234;
        rd2("after_edge", 5'd3, 1'b1, 5'd6, 1'b1);

        for (int i = 1; i < 32; i++) wr(5'(i), 16'(i));
        rd2("fill", 5'd17, 1'b1, 5'd31, 1'b1);

        // sequenced clear
        clr_req = 1'b1;
        #1;
        chk("busy_registered", {31'h0, clr_busy}, 32'h0);
        tick();
        clr_req = 1'b0;
        n = 0; done_cyc = 0; done_cnt = 0;
        while (clr_busy && n < 100) begin
            n++;
            if (clr_done) begin done_cyc = n; done_cnt++; end
            if (n == 5) begin
                wr_addr = 5'd9; wr_data = 16'hAAAA; wr_en = 1'b1;
                rd_addr = {5'd9, 5'd9}; rd_en = 2'b11;
                #1;
                chk("busy_read", rd_data, 32'h0);
            end
            if (n == 6) wr_en = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        chk("clr_busy_len", n, 32);
        chk("clr_done_cyc", done_cyc, 32);
        chk("clr_done_cnt", done_cnt, 1);
        zero_model();
        for (int i = 0; i < 32; i += 2) begin
            rd2("cleared", 5'(i), 1'b1, 5'(i + 1), 1'b1);
            tick();
        end

        // reset in the middle of a clear
        wr(5'd4, 16'h44);
        wr(5'd20, 16'h2020);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, clr_busy}, 32'h0);
        chk("midrst_done", {31'h0, clr_done}, 32'h0);
        zero_model();
        rd2("midrst_rd", 5'd20, 1'b1, 5'd4, 1'b1);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", {31'h0, clr_busy}, 32'h0);

        // clear request outranks a simultaneous write
        wr(5'd7, 16'h77);
        rd2("r7", 5'd7, 1'b1, 5'd7, 1'b1);
        clr_req = 1'b1; wr_addr = 5'd8; wr_data = 16'h88; wr_en = 1'b1;
        tick();
        clr_req = 1'b0; wr_en = 1'b0;
        chk("req_wr_busy", {31'h0, clr_busy}, 32'h1);
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            tick();
        end
        chk("req_wr_len", n, 32);
        zero_model();
        rd2("req_wr_rd", 5'd8, 1'b1, 5'd7, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
